// File: rtl/tx_seq_pkg.sv
// rtl/tx_seq_pkg.sv - shared types and helpers for the multi-byte transmit sequencer
package tx_seq_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      XMIT = 1'b1
   } state_e;

   // Index width for a word of n bytes; a single-byte word still needs one bit.
   function automatic int idx_width(input int n);
      return (n <= 1) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/byte_sel_mux.sv
// rtl/byte_sel_mux.sv - combinational byte selector: word and byte index in, one byte out
module byte_sel_mux #(
   parameter int NUM_BYTES = 2,
   parameter int BYTE_W    = 8,
   parameter int IW        = 1
) (
   input  logic [NUM_BYTES*BYTE_W-1:0] word_i,
   input  logic [IW-1:0]               idx_i,
   output logic [BYTE_W-1:0]           byte_o
);

   // Explicit compare per lane keeps out-of-range indices at zero instead of X.
   always_comb begin
      byte_o = '0;
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (idx_i == IW'(k)) begin
            byte_o = word_i[k*BYTE_W +: BYTE_W];
         end
      end
   end

endmodule

// File: rtl/tx_seq_mb.sv
// rtl/tx_seq_mb.sv - multi-byte transmit sequencer feeding serial8 one byte at a time
module tx_seq_mb
   import tx_seq_pkg::*;
#(
   parameter int NUM_BYTES = 2,
   parameter int BYTE_W    = 8
) (
   input  logic                                  clk,
   input  logic                                  rst,
   input  logic                                  trmt,
   input  logic [NUM_BYTES*BYTE_W-1:0]           tx_data,
   input  logic                                  lsb_first,
   input  logic                                  byte_sent,
   output logic                                  send_byte,
   output logic [BYTE_W-1:0]                     tx_byte,
   output logic [idx_width(NUM_BYTES)-1:0]       byte_idx,
   output logic                                  busy,
   output logic                                  tx_done
);

   localparam int            IW   = idx_width(NUM_BYTES);
   localparam logic [IW-1:0] LAST = IW'(NUM_BYTES - 1);
   localparam logic [IW-1:0] ONE  = IW'(1);

   state_e                        state_q, state_d;
   logic [IW-1:0]                 cnt_q, cnt_d;
   logic [NUM_BYTES*BYTE_W-1:0]   data_q, data_d;
   logic                          lsb_q, lsb_d;

   logic [NUM_BYTES*BYTE_W-1:0]   sel_word;
   logic                          sel_lsb;
   logic [IW-1:0]                 sel_cnt;
   logic                          send_raw, done_raw;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         data_q  <= '0;
         lsb_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         data_q  <= data_d;
         lsb_q   <= lsb_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      data_d   = data_q;
      lsb_d    = lsb_q;
      send_raw = 1'b0;
      done_raw = 1'b0;
      sel_word = data_q;
      sel_lsb  = lsb_q;
      sel_cnt  = cnt_q;
      case (state_q)
         IDLE: begin
            // Present the live word so byte 0 of the order is valid alongside trmt.
            sel_word = tx_data;
            sel_lsb  = lsb_first;
            sel_cnt  = '0;
            if (trmt) begin
               send_raw = 1'b1;
               data_d   = tx_data;
               lsb_d    = lsb_first;
               cnt_d    = '0;
               state_d  = XMIT;
            end
         end
         XMIT: begin
            if (byte_sent) begin
               if (cnt_q != LAST) begin
                  send_raw = 1'b1;
                  sel_cnt  = cnt_q + ONE;
                  cnt_d    = cnt_q + ONE;
               end else begin
                  done_raw = 1'b1;
                  cnt_d    = '0;
                  if (trmt) begin
                     send_raw = 1'b1;
                     sel_word = tx_data;
                     sel_lsb  = lsb_first;
                     sel_cnt  = '0;
                     data_d   = tx_data;
                     lsb_d    = lsb_first;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // Pulses are Mealy, so they must be forced low while reset is held.
   assign send_byte = send_raw & ~rst;
   assign tx_done   = done_raw & ~rst;
   assign busy      = (state_q == XMIT);
   assign byte_idx  = sel_lsb ? sel_cnt : (LAST - sel_cnt);

   byte_sel_mux #(
      .NUM_BYTES (NUM_BYTES),
      .BYTE_W    (BYTE_W),
      .IW        (IW)
   ) u_sel (
      .word_i (sel_word),
      .idx_i  (byte_idx),
      .byte_o (tx_byte)
   );

endmodule

// File: tb/tb_tx_seq_mb.sv
// tb/tb_tx_seq_mb.sv - scoreboard bench for tx_seq_mb with 2-, 4- and 1-byte instances
module tb_tx_seq_mb;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   int n_chk = 0;
   int n_err = 0;

   logic        trmt2 = 0, lsb2 = 0, bs2 = 0;
   logic [15:0] tx2 = '0;
   logic        send2, busy2, done2;
   logic [7:0]  byte2;
   logic        idx2;

   logic        trmt4 = 0, lsb4 = 0, bs4 = 0;
   logic [31:0] tx4 = '0;
   logic        send4, busy4, done4;
   logic [7:0]  byte4;
   logic [1:0]  idx4;

   logic        trmt1 = 0, lsb1 = 0, bs1 = 0;
   logic [7:0]  tx1 = '0;
   logic        send1, busy1, done1;
   logic [7:0]  byte1;
   logic        idx1;

   tx_seq_mb #(.NUM_BYTES(2), .BYTE_W(8)) dut2 (
      .clk(clk), .rst(rst), .trmt(trmt2), .tx_data(tx2), .lsb_first(lsb2),
      .byte_sent(bs2), .send_byte(send2), .tx_byte(byte2), .byte_idx(idx2),
      .busy(busy2), .tx_done(done2));

   tx_seq_mb #(.NUM_BYTES(4), .BYTE_W(8)) dut4 (
      .clk(clk), .rst(rst), .trmt(trmt4), .tx_data(tx4), .lsb_first(lsb4),
      .byte_sent(bs4), .send_byte(send4), .tx_byte(byte4), .byte_idx(idx4),
      .busy(busy4), .tx_done(done4));

   tx_seq_mb #(.NUM_BYTES(1), .BYTE_W(8)) dut1 (
      .clk(clk), .rst(rst), .trmt(trmt1), .tx_data(tx1), .lsb_first(lsb1),
      .byte_sent(bs1), .send_byte(send1), .tx_byte(byte1), .byte_idx(idx1),
      .busy(busy1), .tx_done(done1));

   int q2[$];
   int q4[$];
   int q1[$];
   int n_done2 = 0, n_done4 = 0, n_done1 = 0;
   int n_send4 = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int ent(input int idx, input int b);
      return idx * 256 + b;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic smp();
      @(negedge clk);
   endtask

   // Every send_byte must match the next expected {idx, byte} of its instance.
   always @(negedge clk) begin
      if (send2) begin
         if (q2.size() == 0) chk("sb2_extra_send", 1, 0);
         else chk("sb2_byte", ent(int'(idx2), int'(byte2)), q2.pop_front());
      end
      if (send4) begin
         n_send4++;
         if (q4.size() == 0) chk("sb4_extra_send", 1, 0);
         else chk("sb4_byte", ent(int'(idx4), int'(byte4)), q4.pop_front());
      end
      if (send1) begin
         if (q1.size() == 0) chk("sb1_extra_send", 1, 0);
         else chk("sb1_byte", ent(int'(idx1), int'(byte1)), q1.pop_front());
      end
      if (done2) n_done2++;
      if (done4) n_done4++;
      if (done1) n_done1++;
   end

   task automatic pulse_bs2();
      tick(); bs2 = 1;
      tick(); bs2 = 0;
   endtask

   task automatic pulse_bs4();
      tick(); bs4 = 1;
      tick(); bs4 = 0;
   endtask

   initial begin
      int s4;

      #2 rst = 1;
      trmt2 = 1; tx2 = 16'hFFFF;
      smp();
      chk("rst_busy2", busy2, 0);
      chk("rst_send2_gated", send2, 0);
      chk("rst_done2", done2, 0);
      chk("rst_busy4", busy4, 0);
      tick(); trmt2 = 0;
      tick(); rst = 0;
      tick();

      // 2-byte MSB first
      trmt2 = 1; tx2 = 16'hA55A; lsb2 = 0;
      q2.push_back(ent(1, 8'hA5)); q2.push_back(ent(0, 8'h5A));
      smp();
      chk("t1_send", send2, 1);
      chk("t1_byte0", byte2, 8'hA5);
      chk("t1_idx0", idx2, 1);
      chk("t1_busy_idle", busy2, 0);
      tick(); trmt2 = 0;
      smp();
      chk("t1_send_low", send2, 0);
      chk("t1_busy", busy2, 1);
      tick(); bs2 = 1;
      smp();
      chk("t1_send2", send2, 1);
      chk("t1_byte1", byte2, 8'h5A);
      chk("t1_idx1", idx2, 0);
      chk("t1_no_done", done2, 0);
      tick(); bs2 = 0;
      tick();
      tick(); bs2 = 1;
      smp();
      chk("t1_done", done2, 1);
      chk("t1_no_send", send2, 0);
      tick(); bs2 = 0;
      smp();
      chk("t1_idle", busy2, 0);

      // Back-to-back on the final byte_sent
      tick(); trmt2 = 1; tx2 = 16'hABCD;
      q2.push_back(ent(1, 8'hAB)); q2.push_back(ent(0, 8'hCD));
      tick(); trmt2 = 0;
      pulse_bs2();
      tick(); bs2 = 1; trmt2 = 1; tx2 = 16'h1234;
      q2.push_back(ent(1, 8'h12)); q2.push_back(ent(0, 8'h34));
      smp();
      chk("b2b_done", done2, 1);
      chk("b2b_send", send2, 1);
      chk("b2b_byte", byte2, 8'h12);
      chk("b2b_busy", busy2, 1);
      tick(); bs2 = 0; trmt2 = 0;
      smp();
      chk("b2b_busy_after", busy2, 1);
      pulse_bs2();
      pulse_bs2();
      smp();
      chk("b2b_idle", busy2, 0);

      // trmt mid-transfer is ignored
      tick(); trmt2 = 1; tx2 = 16'h0102;
      q2.push_back(ent(1, 8'h01)); q2.push_back(ent(0, 8'h02));
      tick(); trmt2 = 0;
      tick(); trmt2 = 1; tx2 = 16'h7788;
      tick(); trmt2 = 0;
      pulse_bs2();
      pulse_bs2();
      tick();

      // 4-byte LSB first, data changed after capture
      tick(); trmt4 = 1; tx4 = 32'h12345678; lsb4 = 1;
      q4.push_back(ent(0, 8'h78)); q4.push_back(ent(1, 8'h56));
      q4.push_back(ent(2, 8'h34)); q4.push_back(ent(3, 8'h12));
      s4 = n_send4;
      tick(); trmt4 = 0; tx4 = 32'hDEADBEEF; lsb4 = 0;
      for (int i = 0; i < 4; i++) pulse_bs4();
      tick();
      chk("t4_send_count", n_send4 - s4, 4);
      chk("t4_done_count", n_done4, 1);
      chk("t4_idle", busy4, 0);

      // Reset mid-transfer of 4 bytes
      tick(); trmt4 = 1; tx4 = 32'hAABBCCDD; lsb4 = 0;
      q4.push_back(ent(3, 8'hAA)); q4.push_back(ent(2, 8'hBB));
      tick(); trmt4 = 0;
      pulse_bs4();
      tick(); rst = 1; bs4 = 1;
      smp();
      chk("rst4_busy", busy4, 0);
      chk("rst4_send", send4, 0);
      chk("rst4_done", done4, 0);
      tick(); rst = 0; bs4 = 0;
      tick(); bs4 = 1;
      smp();
      chk("rst4_bs_ignored", send4, 0);
      chk("rst4_no_done", done4, 0);
      tick(); bs4 = 0;
      tick(); trmt4 = 1; tx4 = 32'h11223344; lsb4 = 1;
      q4.push_back(ent(0, 8'h44)); q4.push_back(ent(1, 8'h33));
      q4.push_back(ent(2, 8'h22)); q4.push_back(ent(3, 8'h11));
      smp();
      chk("rst4_restart_byte", byte4, 8'h44);
      tick(); trmt4 = 0;
      for (int i = 0; i < 4; i++) pulse_bs4();
      tick();

      // Single-byte instance
      tick(); trmt1 = 1; tx1 = 8'hC3;
      q1.push_back(ent(0, 8'hC3));
      smp();
      chk("t1b_send", send1, 1);
      chk("t1b_byte", byte1, 8'hC3);
      chk("t1b_idx", idx1, 0);
      tick(); trmt1 = 0;
      tick(); bs1 = 1;
      smp();
      chk("t1b_done", done1, 1);
      chk("t1b_no_send", send1, 0);
      tick(); bs1 = 0;
      smp();
      chk("t1b_idle", busy1, 0);

      tick();
      tick();
      chk("end_q2_empty", q2.size(), 0);
      chk("end_q4_empty", q4.size(), 0);
      chk("end_q1_empty", q1.size(), 0);
      chk("end_done2", n_done2, 4);
      chk("end_done4", n_done4, 2);
      chk("end_done1", n_done1, 1);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
